// File: rtl/reg_file_sb.sv
// Register file with a per-entry pending-write scoreboard and a sequential bulk-clear engine.
// Entry 0 always reads as zero; LINK_REG captures PC on an interrupt link write.
module reg_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LINK_REG = 26,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] w,
    input  logic [DATA_W-1:0] wdata,
    input  logic              IRQWrite,
    input  logic [DATA_W-1:0] PC,
    input  logic [ADDR_W-1:0] r1,
    input  logic [ADDR_W-1:0] r2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueDst,
    output logic              busy1,
    output logic              busy2,
    input  logic              ClrReq,
    output logic              ClrBusy
);
    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              clr_busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_en;
    logic              irq_en;

    assign wr_en   = RegWrite && (w != '0) && !clr_busy_q;
    assign irq_en  = IRQWrite && (LINK_IDX != '0) && !clr_busy_q;
    assign ClrBusy = clr_busy_q;

    // A new producer issued in the same cycle as a retiring write keeps the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) busy_d[w] = 1'b0;
        if (IssueValid && (IssueDst != '0)) busy_d[IssueDst] = 1'b1;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] rd;
        rd = mem_q[ra];
        if (BYPASS) begin
            if (irq_en && (ra == LINK_IDX)) rd = PC;
            else if (wr_en && (w == ra)) rd = wdata;
        end
        if (ra == '0) rd = '0;
        return rd;
    endfunction

    always_comb begin
        rdata1 = read_port(r1);
        rdata2 = read_port(r2);
        busy1  = (r1 != '0) && busy_q[r1];
        busy2  = (r2 != '0) && busy_q[r2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q     <= '0;
            state_q    <= StIdle;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wr_en) mem_q[w] <= wdata;
                    // Later assignment wins: PC beats a RegWrite to the link register.
                    if (irq_en) mem_q[LINK_IDX] <= PC;
                    if (ClrReq) begin
                        state_q    <= StClear;
                        idx_q      <= {{(ADDR_W-1){1'b0}}, 1'b1};
                        clr_busy_q <= 1'b1;
                        busy_q     <= '0;
                    end else begin
                        busy_q <= busy_d;
                    end
                end
                StClear: begin
                    mem_q[idx_q] <= '0;
                    idx_q        <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q    <= StIdle;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: vector table, directed multi-cycle sequences and random stimulus
// against an array/queue reference model; a BYPASS=0 copy shares all inputs.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst, RegWrite, IRQWrite, IssueValid, ClrReq;
    logic [4:0]  w, r1, r2, IssueDst;
    logic [31:0] wdata, PC;
    logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic        busy1, busy2, ClrBusy, nb_busy1, nb_busy2, nb_ClrBusy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(26), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .w(w), .wdata(wdata),
        .IRQWrite(IRQWrite), .PC(PC), .r1(r1), .r2(r2), .rdata1(rdata1), .rdata2(rdata2),
        .IssueValid(IssueValid), .IssueDst(IssueDst), .busy1(busy1), .busy2(busy2),
        .ClrReq(ClrReq), .ClrBusy(ClrBusy)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(26), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .w(w), .wdata(wdata),
        .IRQWrite(IRQWrite), .PC(PC), .r1(r1), .r2(r2), .rdata1(nb_rdata1),
        .rdata2(nb_rdata2), .IssueValid(IssueValid), .IssueDst(IssueDst), .busy1(nb_busy1),
        .busy2(nb_busy2), .ClrReq(ClrReq), .ClrBusy(nb_ClrBusy)
    );

    // Reference model: plain arrays plus a queue of entries still awaiting the clear sweep.
    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    int          m_q[$];

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
        bit idle;
        idle = (m_q.size() == 0);
        if (ra == 5'd0) return 32'h0;
        if (byp && idle && IRQWrite && ra == 5'd26) return PC;
        if (byp && idle && RegWrite && w != 5'd0 && w == ra) return wdata;
        return m_reg[ra];
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        return m_busy[ra];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
            m_q.delete();
        end else if (m_q.size() != 0) begin
            m_reg[m_q.pop_front()] = 32'h0;
        end else begin
            if (RegWrite && w != 5'd0) begin
                m_reg[w]  = wdata;
                m_busy[w] = 1'b0;
            end
            if (IRQWrite) m_reg[26] = PC;
            if (IssueValid && IssueDst != 5'd0) m_busy[IssueDst] = 1'b1;
            if (ClrReq) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
                for (int i = 1; i < 32; i++) m_q.push_back(i);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rdata1"}, rdata1, exp_rd(r1, 1'b1));
        check({tag, ".rdata2"}, rdata2, exp_rd(r2, 1'b1));
        check({tag, ".nb_rdata1"}, nb_rdata1, exp_rd(r1, 1'b0));
        check({tag, ".nb_rdata2"}, nb_rdata2, exp_rd(r2, 1'b0));
        check_bit({tag, ".busy1"}, busy1, exp_busy(r1));
        check_bit({tag, ".busy2"}, busy2, exp_busy(r2));
        check_bit({tag, ".ClrBusy"}, ClrBusy, m_q.size() != 0);
    endtask

    task automatic idle_inputs();
        RegWrite = 1'b0; w = 5'd0; wdata = 32'h0; IRQWrite = 1'b0; PC = 32'h0;
        IssueValid = 1'b0; IssueDst = 5'd0; ClrReq = 1'b0; r1 = 5'd0; r2 = 5'd0;
    endtask

    typedef struct {
        logic        rw;
        logic [4:0]  w;
        logic [31:0] wd;
        logic        irq;
        logic [31:0] pc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        iv;
        logic [4:0]  dst;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int n;
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0,
                    32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 5'd0, 32'h1, 1'b0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0,
                    32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0,
                    32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd7, 32'h55, 1'b0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0,
                    32'h55, 32'h55, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 5'd26, 32'h11, 1'b1, 32'h400, 5'd26, 5'd26, 1'b0, 5'd0,
                    32'h400, 32'h400, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd26, 5'd7, 1'b0, 5'd0,
                    32'h400, 32'h55, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd3,
                    32'h0, 32'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5'd3, 32'hAA, 1'b0, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3,
                    32'hAA, 32'hAA, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0,
                    32'hAA, 32'h0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 5'd3, 32'hBB, 1'b0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0,
                    32'hBB, 32'h0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd3, 5'd5, 1'b0, 5'd0,
                    32'hBB, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd3, 1'b1, 5'd0,
                    32'h0, 32'hBB, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b1, 32'h123, 5'd26, 5'd3, 1'b1, 5'd9,
                    32'h123, 32'hBB, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd9, 5'd26, 1'b0, 5'd0,
                    32'h0, 32'h123, 1'b1, 1'b0};

        // Reset
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        r1 = 5'd5; r2 = 5'd26;
        #1;
        check("reset.rdata1", rdata1, 32'h0);
        check("reset.rdata2", rdata2, 32'h0);
        check_bit("reset.ClrBusy", ClrBusy, 1'b0);
        check_bit("reset.busy1", busy1, 1'b0);

        // Vector table
        foreach (tbl[i]) begin
            RegWrite = tbl[i].rw; w = tbl[i].w; wdata = tbl[i].wd;
            IRQWrite = tbl[i].irq; PC = tbl[i].pc; r1 = tbl[i].r1; r2 = tbl[i].r2;
            IssueValid = tbl[i].iv; IssueDst = tbl[i].dst;
            #1;
            check($sformatf("vec%0d.rdata1", i), rdata1, tbl[i].e1);
            check($sformatf("vec%0d.rdata2", i), rdata2, tbl[i].e2);
            check_bit($sformatf("vec%0d.busy1", i), busy1, tbl[i].eb1);
            check_bit($sformatf("vec%0d.busy2", i), busy2, tbl[i].eb2);
            step();
        end
        idle_inputs();

        // No forwarding without BYPASS
        RegWrite = 1'b1; w = 5'd7; wdata = 32'h77; r1 = 5'd7;
        #1;
        check("nobypass.old_value", nb_rdata1, 32'h55);
        check("bypass.new_value", rdata1, 32'h77);
        step();
        idle_inputs();

        // Bulk clear: write sampled with ClrReq completes, sweep lasts 31 cycles
        ClrReq = 1'b1; RegWrite = 1'b1; w = 5'd12; wdata = 32'hC0;
        step();
        idle_inputs();
        r1 = 5'd12; r2 = 5'd9;
        #1;
        check_bit("clr.start_busy", ClrBusy, 1'b1);
        check("clr.req_write_completes", rdata1, 32'hC0);
        check_bit("clr.busy_bits_cleared", busy2, 1'b0);
        n = 0;
        while (ClrBusy && n < 100) begin
            RegWrite = 1'b1; w = 5'd20; wdata = 32'hFFFF; IRQWrite = 1'b1; PC = 32'h999;
            IssueValid = 1'b1; IssueDst = 5'd4; ClrReq = 1'b1; r1 = 5'd20; r2 = 5'd26;
            #1;
            check_all("clr.window");
            n++;
            step();
        end
        idle_inputs();
        check("clr.cycles", n, 32'd31);
        for (int i = 0; i < 32; i++) begin
            r1 = 5'(i); r2 = 5'(i);
            #1;
            check($sformatf("clr.entry%0d", i), rdata1, 32'h0);
            check_bit($sformatf("clr.busy%0d", i), busy2, 1'b0);
        end

        // Reset in the middle of a sweep
        RegWrite = 1'b1; w = 5'd30; wdata = 32'h30; IssueValid = 1'b1; IssueDst = 5'd10;
        step();
        idle_inputs();
        ClrReq = 1'b1;
        step();
        ClrReq = 1'b0;
        repeat (9) step();
        #1;
        check_bit("midclr.active", ClrBusy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        r1 = 5'd30; r2 = 5'd10;
        #1;
        check_bit("midclr.rst_idle", ClrBusy, 1'b0);
        check("midclr.rst_entry30", rdata1, 32'h0);
        check_bit("midclr.rst_busy10", busy2, 1'b0);
        ClrReq = 1'b1;
        step();
        ClrReq = 1'b0;
        #1;
        check_bit("midclr.new_req", ClrBusy, 1'b1);
        n = 0;
        while (ClrBusy && n < 100) begin
            n++;
            step();
        end
        check("midclr.new_req_cycles", n, 32'd31);

        // Random stimulus against the model
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 149) == 0);
            ClrReq     = ($urandom_range(0, 49) == 0);
            RegWrite   = 1'($urandom_range(0, 1));
            IRQWrite   = ($urandom_range(0, 7) == 0);
            IssueValid = 1'($urandom_range(0, 1));
            w          = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            IssueDst   = 5'($urandom_range(0, 7));
            r1         = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r2         = $urandom_range(0, 3) == 0 ? 5'd26 : 5'($urandom_range(0, 31));
            wdata      = $urandom;
            PC         = $urandom;
            #1;
            check_all($sformatf("rand%0d", c));
            step();
        end
        rst = 1'b0;
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and port data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2^ADDR_W, and entry 0 is hard-wired zero.
REQ-003 SHALL have parameter LINK_REG, default 26, the index written with PC on IRQWrite.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data forwards to the read ports.
REQ-005 SHALL have port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have ports: RegWrite  in  1  write enable; w  in  ADDR_W  write address; wdata  in  DATA_W  write data.
REQ-008 SHALL have ports: IRQWrite  in  1  interrupt link write; PC  in  DATA_W  address saved to LINK_REG.
REQ-009 SHALL have ports: r1, r2  in  ADDR_W  read addresses; rdata1, rdata2  out  DATA_W  read data (combinational).
REQ-010 SHALL have ports: IssueValid  in  1  producer issued; IssueDst  in  ADDR_W  its destination register.
REQ-011 SHALL have ports: busy1, busy2  out  1  pending-write (scoreboard) flag for r1/r2 (combinational).
REQ-012 SHALL have ports: ClrReq  in  1  bulk-clear request; ClrBusy  out  1  clear engine active.

Function
REQ-013 SHALL return 0 on rdataN and 0 on busyN whenever rN==0, irrespective of all other inputs.
REQ-014 SHALL, when RegWrite=1, w!=0 and ClrBusy=0, write wdata into Reg[w] at the clock edge; RegWrite with w==0 SHALL change nothing.
REQ-015 SHALL, when IRQWrite=1 and ClrBusy=0, write PC into Reg[LINK_REG]; if RegWrite also targets LINK_REG in the same cycle, PC SHALL win.
REQ-016 SHALL, with BYPASS=1, drive rdataN=PC if IRQWrite=1, ClrBusy=0 and rN==LINK_REG; otherwise wdata if RegWrite=1, ClrBusy=0, w!=0 and w==rN; otherwise Reg[rN].
REQ-017 SHALL, with BYPASS=0, drive rdataN=Reg[rN] (the pre-edge value) with no forwarding.
REQ-018 SHALL keep one busy bit per entry: IssueValid=1 with IssueDst!=0 sets busy[IssueDst]; RegWrite=1 with w!=0 clears busy[w]; both updates take effect at the edge.
REQ-019 SHALL, when a set and a clear address the same entry in the same cycle, leave that bit set (the new producer wins).
REQ-020 SHALL NOT let IRQWrite affect any busy bit; busyN SHALL reflect the registered bit only, with no same-cycle forwarding.
REQ-021 SHALL implement a clear FSM with states IDLE and CLEAR and an index counter of width ADDR_W.
REQ-022 SHALL, in IDLE with ClrReq=1, go to CLEAR at the next edge, load the index with 1, and clear all busy bits at that same edge.
REQ-023 SHALL, in CLEAR, zero Reg[index] at each edge and increment the index; after zeroing entry depth-1 it SHALL return to IDLE, so CLEAR lasts exactly depth-1 cycles.
REQ-024 SHALL drive ClrBusy=1 exactly while the state is CLEAR.
REQ-025 SHALL ignore RegWrite, IRQWrite, IssueValid and ClrReq while in CLEAR; reads stay live and return current array contents.
REQ-026 SHALL give ClrReq no effect on the data array in the cycle it is sampled in IDLE; a RegWrite or IRQWrite in that cycle still completes.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, zero all entries, clear all busy bits, force IDLE with index 0, and drive ClrBusy=0; rst SHALL take priority over every other input, including mid-CLEAR.

Verification
REQ-028 SHALL be covered by: write Reg[5]=0xDEADBEEF, then read r1=5 -> rdata1=0xDEADBEEF; and read r2=0 after RegWrite w=0 wdata=0x1 -> rdata2=0.
REQ-029 SHALL be covered by: BYPASS=1 with RegWrite w=7 wdata=0x55 and r1=7 in the same cycle -> rdata1=0x55 that cycle; with BYPASS=0 -> old value.
REQ-030 SHALL be covered by: RegWrite w=26 wdata=0x11 and IRQWrite PC=0x400 in the same cycle -> Reg[26]=0x400, and same-cycle rdata1 (r1=26) = 0x400.
REQ-031 SHALL be covered by: IssueValid IssueDst=3 -> busy1(r1=3)=1 next cycle; then RegWrite w=3 together with IssueValid IssueDst=3 -> busy stays 1; then RegWrite w=3 alone -> busy1=0.
REQ-032 SHALL be covered by: ClrReq with ADDR_W=5 and registers preloaded -> ClrBusy high for 31 cycles, a RegWrite during that window has no effect, and all entries are 0 afterwards.
REQ-033 SHALL be covered by: rst asserted at cycle 10 of CLEAR -> next cycle ClrBusy=0, all entries 0, busy bits 0, and a new ClrReq is accepted.
